pll_lock_monitor: RTL and testbench
===================================

PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 16: refclk cycles pll_rst is held per PLL reset pulse; legal range 1..2^20-1.
REQ-002 Parameter LOCK_TIMEOUT_CYCLES, default 500000: refclk cycles allowed for lock after a pll_rst pulse ends; legal range 1..2^20-1.
REQ-003 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive locked cycles required before release; legal range 1..2^20-1.
REQ-004 refclk  input  1  sole clock; free-running reference, independent of PLL lock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 locked  input  1  PLL lock indicator, asynchronous to refclk.
REQ-007 relock_req  input  1  single-cycle request to force a PLL reset cycle.
REQ-008 pll_rst  output  1  active-high reset driven to the PLL.
REQ-009 sys_rst  output  1  active-high reset for logic on the PLL output clocks.
REQ-010 ready  output  1  high while the PLL is locked and released.
REQ-011 lost_count  output  8  saturating count of lock-loss events while in RUN.

Function
REQ-012 locked SHALL pass through a 2-flop synchronizer; lock_s denotes its output (2-cycle latency).
REQ-013 FSM states SHALL be RESET_PLL, WAIT_LOCK, STABLE, RUN; a single shared 20-bit counter SHALL be cleared on every state transition.
REQ-014 RESET_PLL: counter increments each cycle; on reaching PLL_RST_CYCLES-1 SHALL go to WAIT_LOCK.
REQ-015 WAIT_LOCK: lock_s=1 SHALL go to STABLE; else counter reaching LOCK_TIMEOUT_CYCLES-1 SHALL go to RESET_PLL.
REQ-016 STABLE: lock_s=0 SHALL go to WAIT_LOCK; counter reaching LOCK_STABLE_CYCLES-1 with lock_s=1 SHALL go to RUN.
REQ-017 RUN: lock_s=0 SHALL go to RESET_PLL and increment lost_count, saturating at 255.
REQ-018 relock_req=1 in any state SHALL go to RESET_PLL, taking priority over all other transitions; no lost_count increment unless lock_s=0 in RUN on the same cycle.
REQ-019 Outputs SHALL be registered: pll_rst=1 iff next state RESET_PLL; sys_rst=0 iff next state RUN; ready = ~sys_rst.
REQ-020 ready SHALL rise on the same edge sys_rst falls; pll_rst and ready SHALL never both be 1.

Reset
REQ-021 On rst assertion, asynchronously: state=RESET_PLL, counter=0, synchronizer flops=0, pll_rst=1, sys_rst=1, ready=0, lost_count=0.
REQ-022 After rst deassertion, a full PLL_RST_CYCLES pulse SHALL be issued before WAIT_LOCK; rst mid-sequence SHALL restart from RESET_PLL.

Configuration
REQ-023 Macro PLL_LOCK_MONITOR_LOSS_COUNT_EN defined: lost_count SHALL behave per REQ-017/REQ-018.
REQ-024 Macro undefined: lost_count SHALL be constant 8'd0 and no counter register SHALL be synthesized; all other behaviour unchanged.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8)
REQ-025 Release rst, assert locked at cycle 10 -> pll_rst high exactly 4 cycles, then ready=1/sys_rst=0 at cycle 10+2+8 (+/-1 edge per REQ-019 registration), stays.
REQ-026 locked never asserts -> pll_rst pulses 4 cycles every 36 cycles, sys_rst stays 1, ready stays 0.
REQ-027 locked glitches low 3 cycles in STABLE -> returns to WAIT_LOCK, ready delayed by full 8-cycle stable window after relock.
REQ-028 locked drops in RUN -> ready=0 within 3 cycles, pll_rst pulse of 4 cycles, lost_count 0->1; 300 drops -> lost_count=255 (macro defined) or 0 (undefined).
REQ-029 relock_req pulse in RUN with locked=1 -> RESET_PLL next cycle, sys_rst=1, lost_count unchanged.
REQ-030 rst asserted mid-STABLE -> outputs reach reset values without a refclk edge; full sequence restarts.

Source files
------------

// File: rtl/pll_lock_monitor_if.sv
// pll_lock_monitor_if: signals between the PLL lock monitor and the PLL /
// downstream reset tree. The monitor side uses the master modport; the PLL
// model (or the surrounding logic) uses the slave modport.
interface pll_lock_monitor_if;
    logic       locked;      // raw PLL lock flag, asynchronous to refclk
    logic       relock_req;  // single-cycle request for a forced PLL reset
    logic       pll_rst;     // reset driven into the PLL
    logic       sys_rst;     // reset for logic clocked by the PLL outputs
    logic       ready;       // PLL locked and downstream logic released
    logic [7:0] lost_count;  // saturating count of lock losses while running

    modport master (
        input  locked,
        input  relock_req,
        output pll_rst,
        output sys_rst,
        output ready,
        output lost_count
    );

    modport slave (
        output locked,
        output relock_req,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  lost_count
    );
endinterface

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: sequences the PLL reset, waits for a stable lock, then
// releases the downstream reset. A loss of lock while running, or an explicit
// relock request, restarts the whole sequence with a fresh PLL reset pulse.
//
// Optional feature: define PLL_LOCK_MONITOR_LOSS_COUNT_EN to build the
// saturating lock-loss counter; otherwise lost_count is tied to zero and no
// counter register exists.
module pll_lock_monitor #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024
) (
    input  logic                 refclk,
    input  logic                 rst,
    pll_lock_monitor_if.master   mon
);

    // Terminal counts of the shared 20-bit phase counter
    localparam logic [19:0] RST_LAST     = 20'(PLL_RST_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [19:0] STABLE_LAST  = 20'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [19:0] cnt_reg;
    logic [19:0] cnt_next;
    logic [1:0]  sync_reg;
    logic        lock_s;
    logic        pll_rst_reg;
    logic        sys_rst_reg;
    logic        ready_reg;

    // Two-flop synchronizer bringing the asynchronous lock flag into refclk
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], mon.locked};
        end
    end

    assign lock_s = sync_reg[1];

    // Next-state decision; a relock request overrides every other transition
    always_comb begin
        state_next = state_reg;
        if (mon.relock_req) begin
            state_next = RESET_PLL;
        end else begin
            case (state_reg)
                RESET_PLL: begin
                    if (cnt_reg == RST_LAST) begin
                        state_next = WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_next = STABLE;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_next = RESET_PLL;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_next = WAIT_LOCK;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_next = RESET_PLL;
                    end
                end
                default: begin
                    state_next = RESET_PLL;
                end
            endcase
        end
    end

    // Counter restarts on every transition and on a relock request, so a
    // forced relock always produces a full-length PLL reset pulse. It has no
    // use while running, so it is frozen there.
    always_comb begin
        cnt_next = cnt_reg;
        if (mon.relock_req || (state_next != state_reg)) begin
            cnt_next = 20'd0;
        end else if (state_reg != RUN) begin
            cnt_next = cnt_reg + 20'd1;
        end
    end

    // State, counter and registered outputs decoded from the next state
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_reg   <= RESET_PLL;
            cnt_reg     <= 20'd0;
            pll_rst_reg <= 1'b1;
            sys_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pll_rst_reg <= (state_next == RESET_PLL);
            sys_rst_reg <= (state_next != RUN);
            ready_reg   <= (state_next == RUN);
        end
    end

    assign mon.pll_rst = pll_rst_reg;
    assign mon.sys_rst = sys_rst_reg;
    assign mon.ready   = ready_reg;

`ifdef PLL_LOCK_MONITOR_LOSS_COUNT_EN
    logic [7:0] lost_count_reg;
    logic       loss_event;

    // A loss is a deasserted synchronized lock while running; it counts even
    // when a relock request lands on the same cycle.
    assign loss_event = (state_reg == RUN) && !lock_s;

    // Saturating lock-loss counter
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lost_count_reg <= 8'd0;
        end else if (loss_event && (lost_count_reg != 8'hFF)) begin
            lost_count_reg <= lost_count_reg + 8'd1;
        end
    end

    assign mon.lost_count = lost_count_reg;
`else
    assign mon.lost_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb_pll_lock_monitor: table-driven and randomized checking of the PLL lock
// monitor with short phase lengths (reset 4, timeout 32, stable 8). A
// phase/age reference model tracks the expected behaviour every cycle.
module tb_pll_lock_monitor;

    localparam int P = 4;
    localparam int T = 32;
    localparam int S = 8;

    logic refclk = 1'b0;
    logic rst    = 1'b0;

    pll_lock_monitor_if bus();

    pll_lock_monitor #(
        .PLL_RST_CYCLES      (P),
        .LOCK_TIMEOUT_CYCLES (T),
        .LOCK_STABLE_CYCLES  (S)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .mon    (bus)
    );

    always #5 refclk = ~refclk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: which phase we are in and how many edges spent there
    typedef enum int {M_RESET, M_WAIT, M_STABLE, M_RUN} mphase_t;
    mphase_t m_phase;
    int      m_age;
    int      m_lost;
    bit      m_hist[$];   // raw lock samples still in flight through the synchronizer

    typedef struct {
        bit locked;
        bit relock;
        int n;
        bit pll;
        bit sys;
        bit rdy;
        int lost;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [7:0] lost_expect(input int v);
`ifdef PLL_LOCK_MONITOR_LOSS_COUNT_EN
        return 8'(v);
`else
        return (v == v) ? 8'd0 : 8'd0;
`endif
    endfunction

    function automatic logic [10:0] dut_out();
        return {bus.pll_rst, bus.sys_rst, bus.ready, bus.lost_count};
    endfunction

    function automatic logic [10:0] model_out();
        return {m_phase == M_RESET, m_phase != M_RUN, m_phase == M_RUN, lost_expect(m_lost)};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got pll_rst/sys_rst/ready/lost_count=%b/%b/%b/%0d need %b/%b/%b/%0d",
                     name, $time, act[10], act[9], act[8], act[7:0], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d need %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = M_RESET;
        m_age   = 0;
        m_lost  = 0;
        m_hist.delete();
        m_hist.push_back(1'b0);
        m_hist.push_back(1'b0);
    endtask

    // One refclk edge of the expected behaviour
    task automatic model_edge(input bit l, input bit r);
        bit      ls;
        mphase_t nxt;
        ls = m_hist.pop_front();
        m_hist.push_back(l);
        if (m_phase == M_RUN && !ls && m_lost < 255) m_lost++;
        m_age++;
        nxt = m_phase;
        if (r) begin
            nxt = M_RESET;
        end else begin
            case (m_phase)
                M_RESET:  if (m_age >= P) nxt = M_WAIT;
                M_WAIT:   if (ls) nxt = M_STABLE; else if (m_age >= T) nxt = M_RESET;
                M_STABLE: if (!ls) nxt = M_WAIT; else if (m_age >= S) nxt = M_RUN;
                M_RUN:    if (!ls) nxt = M_RESET;
                default:  nxt = M_RESET;
            endcase
        end
        if (r || nxt != m_phase) m_age = 0;
        m_phase = nxt;
    endtask

    // Drive inputs, advance one edge, compare against the model 1 time unit later
    task automatic step(input bit l, input bit r, input string name);
        bus.locked     = l;
        bus.relock_req = r;
        @(posedge refclk);
        model_edge(l, r);
        #1;
        check(name, dut_out(), model_out());
    endtask

    // Assert reset between edges, confirm the outputs fall back immediately
    task automatic do_reset();
        rst            = 1'b1;
        bus.locked     = 1'b0;
        bus.relock_req = 1'b0;
        #2;
        check("async_reset", dut_out(), 11'b110_0000_0000);
        model_reset();
        @(posedge refclk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_ready;
        int prev_pll;
        int ready_cnt;
        int rises[$];
        int waited;

        // Reset release, lock at edge 10, relock request, then a loss of lock
        tbl[0]  = '{0, 0, 3,  1, 1, 0, 0};
        tbl[1]  = '{0, 0, 6,  0, 1, 0, 0};
        tbl[2]  = '{1, 0, 10, 0, 1, 0, 0};
        tbl[3]  = '{1, 0, 5,  0, 0, 1, 0};
        tbl[4]  = '{1, 1, 1,  1, 1, 0, 0};
        tbl[5]  = '{1, 0, 3,  1, 1, 0, 0};
        tbl[6]  = '{1, 0, 9,  0, 1, 0, 0};
        tbl[7]  = '{1, 0, 2,  0, 0, 1, 0};
        tbl[8]  = '{0, 0, 2,  0, 0, 1, 0};
        tbl[9]  = '{0, 0, 4,  1, 1, 0, 1};
        tbl[10] = '{0, 0, 2,  0, 1, 0, 1};

        bus.locked     = 1'b0;
        bus.relock_req = 1'b0;
        #1;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                step(tbl[i].locked, tbl[i].relock, "tbl_model");
                check("tbl_row", dut_out(),
                      {tbl[i].pll, tbl[i].sys, tbl[i].rdy, lost_expect(tbl[i].lost)});
            end
            $display("row %0d: locked=%0d relock=%0d cycles=%0d pll_rst=%0d sys_rst=%0d ready=%0d",
                     i, tbl[i].locked, tbl[i].relock, tbl[i].n, bus.pll_rst, bus.sys_rst, bus.ready);
        end

        // Lock never arrives: PLL reset pulse repeats every reset+timeout cycles
        do_reset();
        prev_pll  = 1;
        ready_cnt = 0;
        for (int e = 1; e <= 75; e++) begin
            step(1'b0, 1'b0, "timeout_model");
            if (bus.pll_rst && prev_pll == 0) rises.push_back(e);
            if (bus.ready) ready_cnt++;
            prev_pll = int'(bus.pll_rst);
        end
        check_int("timeout_rises", rises.size(), 2);
        check_int("timeout_rise0", (rises.size() > 0) ? rises[0] : -1, P + T);
        check_int("timeout_rise1", (rises.size() > 1) ? rises[1] : -1, 2 * (P + T));
        check_int("timeout_ready", ready_cnt, 0);
        $display("seq timeout: pll_rst rising edges=%0d ready cycles=%0d", rises.size(), ready_cnt);

        // Three-cycle lock glitch while in STABLE restarts the stable window
        do_reset();
        first_ready = -1;
        for (int e = 1; e <= 25; e++) begin
            step((e >= 7 && e <= 9) ? 1'b0 : 1'b1, 1'b0, "glitch_model");
            if (bus.ready && first_ready < 0) first_ready = e;
        end
        check_int("glitch_ready_edge", first_ready, 20);
        $display("seq glitch: ready first seen at edge %0d", first_ready);

        // Reset mid-STABLE, then the full sequence from the top
        do_reset();
        for (int e = 1; e <= 7; e++) step(1'b1, 1'b0, "midreset_model");
        do_reset();
        first_ready = -1;
        for (int e = 1; e <= 16; e++) begin
            step(1'b1, 1'b0, "midreset_restart");
            if (bus.ready && first_ready < 0) first_ready = e;
        end
        check_int("midreset_ready_edge", first_ready, P + 1 + S);
        $display("seq midreset: ready first seen at edge %0d", first_ready);

        // 300 lock losses in RUN: counter saturates
        do_reset();
        waited = 0;
        while (m_phase != M_RUN && waited < 40) begin
            step(1'b1, 1'b0, "drops_model");
            waited++;
        end
        check_int("drops_reach_run", int'(bus.ready), 1);
        for (int d = 0; d < 300; d++) begin
            step(1'b0, 1'b0, "drops_model");
            for (int k = 0; k < 3; k++) step(1'b1, 1'b0, "drops_model");
            waited = 0;
            while (m_phase != M_RUN && waited < 40) begin
                step(1'b1, 1'b0, "drops_model");
                waited++;
            end
            if (waited >= 40) check_int("drops_relock_bound", waited, 0);
        end
        check("drops_saturate", dut_out(), {3'b001, lost_expect(255)});
        $display("seq drops: lost_count=%0d after 300 losses", bus.lost_count);

        // Random lock behaviour, occasional relock requests and resets
        begin
            bit lk;
            int run_left;
            do_reset();
            lk       = 1'b0;
            run_left = 0;
            for (int c = 0; c < 4000; c++) begin
                if (run_left == 0) begin
                    lk       = ($urandom_range(0, 3) != 0);
                    run_left = lk ? $urandom_range(1, 60) : $urandom_range(1, 45);
                end
                run_left--;
                if ($urandom_range(0, 999) == 0) begin
                    do_reset();
                end else begin
                    step(lk, ($urandom_range(0, 99) == 0), "random_model");
                end
            end
            $display("seq random: 4000 cycles, final lost_count=%0d", bus.lost_count);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
